// File: rtl/spiflash_read_seq_if.sv
// Request, flash-pin and receive-FIFO signals of the SPI flash read sequencer.
interface spiflash_read_seq_if #(
  parameter int LENW = 16
);
  logic            i_start;
  logic [23:0]     i_addr;
  logic [LENW-1:0] i_len;
  logic            o_busy;
  logic            o_done;
  logic            o_cs_n;
  logic            o_sck;
  logic            o_mosi;
  logic            i_miso;
  logic            o_fifo_wr_en;
  logic [7:0]      o_fifo_wr_data;
  logic            i_fifo_full;

  modport slave (
    input  i_start, i_addr, i_len, i_miso, i_fifo_full,
    output o_busy, o_done, o_cs_n, o_sck, o_mosi, o_fifo_wr_en, o_fifo_wr_data
  );

  modport master (
    output i_start, i_addr, i_len, i_miso, i_fifo_full,
    input  o_busy, o_done, o_cs_n, o_sck, o_mosi, o_fifo_wr_en, o_fifo_wr_data
  );
endinterface

// File: rtl/spiflash_read_seq.sv
// SPI flash READ (0x03) sequencer, mode 0, MSB first. Sends command plus
// 24-bit address, clocks in len bytes and pushes them into the receive FIFO,
// pausing SCK between bytes while a captured byte cannot be pushed.
module spiflash_read_seq #(
  parameter int CLKDIV = 2,
  parameter int LENW   = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  spiflash_read_seq_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, STALL, CS_GAP, DONE} state_t;

  localparam logic [8:0] HALF_LAST = 9'(CLKDIV - 1);
  localparam logic [8:0] GAP_LAST  = 9'(2 * CLKDIV - 1);

  state_t          state, state_nxt;
  logic [8:0]      div_cnt;
  logic            sck_hi;
  logic [31:0]     sh_out;
  logic            cmd_ph;
  logic [5:0]      bit_cnt;
  logic [LENW-1:0] byte_cnt;
  logic [6:0]      rx;
  logic            pend;
  logic [7:0]      pend_data;

  logic half_end, fall, low_end, more_bits, accept, wr_en, byte_cap;

  assign half_end  = (div_cnt == HALF_LAST);
  assign fall      = (state == SHIFT) && sck_hi && half_end;
  assign low_end   = (state == SHIFT) && !sck_hi && half_end;
  // Any bit left: command/address, rest of a byte, or further bytes.
  assign more_bits = cmd_ph || (bit_cnt != 6'd0) || (byte_cnt != '0);
  assign accept    = ((state == IDLE) || (state == DONE)) && bus.i_start;
  assign wr_en     = pend && !bus.i_fifo_full;
  assign byte_cap  = fall && !cmd_ph && (bit_cnt == 6'd7);

  assign bus.o_busy         = (state == CS_SETUP) || (state == SHIFT) ||
                              (state == STALL) || (state == CS_GAP);
  assign bus.o_done         = (state == DONE);
  assign bus.o_cs_n         = !((state == CS_SETUP) || (state == SHIFT) || (state == STALL));
  assign bus.o_sck          = (state == SHIFT) && sck_hi;
  assign bus.o_mosi         = ((state == CS_SETUP) || (state == SHIFT)) && sh_out[31];
  assign bus.o_fifo_wr_en   = wr_en;
  assign bus.o_fifo_wr_data = pend_data;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state: stall only at a byte boundary where the previous byte is still stuck.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (bus.i_start) state_nxt = (bus.i_len == '0) ? DONE : CS_SETUP;
        else             state_nxt = IDLE;
      end
      CS_SETUP: if (half_end) state_nxt = SHIFT;
      SHIFT: begin
        if (low_end) begin
          if (!more_bits)           state_nxt = CS_GAP;
          else if (pend && !wr_en)  state_nxt = STALL;
        end
      end
      STALL:  if (wr_en) state_nxt = SHIFT;
      CS_GAP: if ((div_cnt == GAP_LAST) && (!pend || wr_en)) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: half-period timer, shifters, bit/byte counters, pending byte.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      div_cnt   <= '0;
      sck_hi    <= 1'b0;
      sh_out    <= '0;
      cmd_ph    <= 1'b0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      rx        <= '0;
      pend      <= 1'b0;
      pend_data <= '0;
    end else begin
      if ((state_nxt != state) || ((state == SHIFT) && half_end))
        div_cnt <= '0;
      else if ((state == CS_SETUP) || (state == SHIFT) ||
               ((state == CS_GAP) && (div_cnt != GAP_LAST)))
        div_cnt <= div_cnt + 9'd1;

      if (fall)
        sck_hi <= 1'b0;
      else if ((state_nxt == SHIFT) && ((state != SHIFT) || low_end))
        sck_hi <= 1'b1;

      if (accept) begin
        sh_out   <= {8'h03, bus.i_addr};
        byte_cnt <= bus.i_len;
        cmd_ph   <= 1'b1;
        bit_cnt  <= '0;
      end else if (fall) begin
        sh_out <= {sh_out[30:0], 1'b0};
        if (cmd_ph) begin
          if (bit_cnt == 6'd31) begin
            cmd_ph  <= 1'b0;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end else begin
          rx <= {rx[5:0], bus.i_miso};
          if (bit_cnt == 6'd7) begin
            bit_cnt  <= '0;
            byte_cnt <= byte_cnt - LENW'(1);
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
      end

      if (byte_cap) begin
        pend      <= 1'b1;
        pend_data <= {rx, bus.i_miso};
      end else if (wr_en) begin
        pend <= 1'b0;
      end
    end
  end
endmodule
